// File: rtl/pi1_ram_responder_if.sv
// pi1_ram_responder_if: PI1 bus between a requester (master) and a RAM responder (slave).
interface pi1_ram_responder_if #(
    parameter int ARCHBITSZ = 32,
    parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
);
    logic [1:0]             pi1_op_i;
    logic [ADDRBITSZ-1:0]   pi1_addr_i;
    logic [ARCHBITSZ-1:0]   pi1_data_i;
    logic [ARCHBITSZ-1:0]   pi1_data_o;
    logic [ARCHBITSZ/8-1:0] pi1_sel_i;
    logic                   pi1_rdy_o;
    logic                   err_o;
    modport master (
        output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
        input  pi1_data_o, pi1_rdy_o, err_o
    );
    modport slave (
        input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
        output pi1_data_o, pi1_rdy_o, err_o
    );
endinterface

// File: rtl/pi1_ram_responder.sv
// pi1_ram_responder: PI1 slave word RAM with WAITCNT wait states; PI1_RAM_RANGECHK_EN enables out-of-range checking.
module pi1_ram_responder #(
    parameter int ARCHBITSZ = 32,
    parameter int DEPTH     = 1024,
    parameter int WAITCNT   = 0
) (
    input logic clk_i,
    input logic rst_i,
    pi1_ram_responder_if.slave bus
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int BYTES = ARCHBITSZ / 8;
    localparam logic [3:0] LAST = WAITCNT > 0 ? 4'(WAITCNT - 1) : 4'd0;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [1:0] op_q;
    logic [IDXW-1:0] idx_q;
    logic [ARCHBITSZ-1:0] data_q;
    logic [BYTES-1:0] sel_q;
    logic oor_q;
    logic oor_in;
    logic [ARCHBITSZ-1:0] mem [DEPTH];
`ifdef PI1_RAM_RANGECHK_EN
    assign oor_in = |(bus.pi1_addr_i >> IDXW);
`else
    assign oor_in = 1'b0;
`endif
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt <= '0;
            op_q <= '0;
            idx_q <= '0;
            data_q <= '0;
            sel_q <= '0;
            oor_q <= 1'b0;
            bus.pi1_rdy_o <= 1'b1;
            bus.pi1_data_o <= '0;
            bus.err_o <= 1'b0;
        end else begin
            bus.err_o <= 1'b0;
            case (state)
                IDLE: if (bus.pi1_op_i != 2'b00) begin
                    op_q <= bus.pi1_op_i;
                    idx_q <= bus.pi1_addr_i[IDXW-1:0];
                    data_q <= bus.pi1_data_i;
                    sel_q <= bus.pi1_sel_i;
                    oor_q <= oor_in;
                    cnt <= '0;
                    bus.pi1_rdy_o <= 1'b0;
                    state <= WAITCNT > 0 ? WAIT : ACCESS;
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    state <= cnt == LAST ? ACCESS : WAIT;
                end
                ACCESS: begin
                    if (op_q[1]) bus.pi1_data_o <= oor_q ? '0 : mem[idx_q];
                    bus.err_o <= oor_q;
                    bus.pi1_rdy_o <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // RW reads the old word above and writes here on the same edge, so the swap is atomic.
    always_ff @(posedge clk_i) begin
        if (state == ACCESS && op_q[0] && !oor_q)
            for (int b = 0; b < BYTES; b++)
                if (sel_q[b]) mem[idx_q][8*b +: 8] <= data_q[8*b +: 8];
    end
endmodule

// File: tb/tb_pi1_ram_responder.sv
// tb_pi1_ram_responder: directed and random PI1 requests checked against an array model of the RAM.
module tb_pi1_ram_responder;
    localparam int DEPTH = 16;
    localparam int WC = 3;
`ifdef PI1_RAM_RANGECHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_data = '0;
    logic [31:0] got;
    always #5 clk_i = ~clk_i;
    pi1_ram_responder_if #(.ARCHBITSZ(32)) bus ();
    pi1_ram_responder #(.ARCHBITSZ(32), .DEPTH(DEPTH), .WAITCNT(WC)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic req(input string tag, input logic [1:0] op, input logic [29:0] addr,
                       input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
        int n = 0;
        int idx = int'(addr % DEPTH);
        bit oor = RC && addr >= DEPTH;
        @(negedge clk_i);
        bus.pi1_op_i = op;
        bus.pi1_addr_i = addr;
        bus.pi1_data_i = d;
        bus.pi1_sel_i = s;
        @(posedge clk_i);
        #1;
        bus.pi1_op_i = 2'b00;
        while (bus.pi1_rdy_o !== 1'b1 && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (op[1]) exp_data = oor ? 32'h0 : ref_mem[idx];
        if (op[0] && !oor)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        rd = bus.pi1_data_o;
        chk({tag, ".lat"}, 32'(n), 32'(WC + 1));
        chk({tag, ".data"}, bus.pi1_data_o, exp_data);
        chk({tag, ".err"}, 32'(bus.err_o), 32'(oor));
        @(posedge clk_i);
        #1;
        chk({tag, ".errpulse"}, 32'(bus.err_o), 32'h0);
    endtask
    initial begin
        bus.pi1_op_i = 2'b00;
        bus.pi1_addr_i = '0;
        bus.pi1_data_i = '0;
        bus.pi1_sel_i = '0;
        #2 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.rdy", 32'(bus.pi1_rdy_o), 32'h1);
        chk("rst.data", bus.pi1_data_o, 32'h0);
        chk("rst.err", 32'(bus.err_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i);
            #1;
            chk("idle.rdy", 32'(bus.pi1_rdy_o), 32'h1);
        end
        for (int i = 0; i < DEPTH; i++) req("fill", 2'b01, 30'(i), $urandom, 4'hf, got);
        req("wr5", 2'b01, 30'd5, 32'hDEADBEEF, 4'hf, got);
        req("rd5", 2'b10, 30'd5, 32'h0, 4'h0, got);
        chk("rd5.const", got, 32'hDEADBEEF);
        req("wr7", 2'b01, 30'd7, 32'h11223344, 4'hf, got);
        req("wr7b", 2'b01, 30'd7, 32'hAABBCCDD, 4'b0101, got);
        req("rd7", 2'b10, 30'd7, 32'h0, 4'hf, got);
        chk("rd7.const", got, 32'h11BB33DD);
        req("wr7z", 2'b01, 30'd7, 32'h99999999, 4'b0000, got);
        req("rd7z", 2'b10, 30'd7, 32'h0, 4'hf, got);
        chk("rd7z.const", got, 32'h11BB33DD);
        req("wr2", 2'b01, 30'd2, 32'h12345678, 4'hf, got);
        req("rw2", 2'b11, 30'd2, 32'hCAFEF00D, 4'hf, got);
        chk("rw2.const", got, 32'h12345678);
        req("rd2", 2'b10, 30'd2, 32'h0, 4'hf, got);
        chk("rd2.const", got, 32'hCAFEF00D);
        req("wr9", 2'b01, 30'd9, 32'h0, 4'hf, got);
        @(negedge clk_i);
        bus.pi1_op_i = 2'b01;
        bus.pi1_addr_i = 30'd9;
        bus.pi1_data_i = 32'hFFFFFFFF;
        bus.pi1_sel_i = 4'hf;
        @(posedge clk_i);
        #1;
        bus.pi1_op_i = 2'b00;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("midrst.rdy", 32'(bus.pi1_rdy_o), 32'h1);
        chk("midrst.data", bus.pi1_data_o, 32'h0);
        exp_data = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        req("rd9", 2'b10, 30'd9, 32'h0, 4'hf, got);
        chk("rd9.const", got, 32'h0);
        req("rd16", 2'b10, 30'd16, 32'h0, 4'hf, got);
        req("wr17", 2'b01, 30'd17, 32'h55AA55AA, 4'hf, got);
        req("rd1", 2'b10, 30'd1, 32'h0, 4'hf, got);
        @(negedge clk_i);
        bus.pi1_op_i = 2'b10;
        bus.pi1_addr_i = 30'd3;
        bus.pi1_sel_i = 4'hf;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i);
            #1;
            chk("b2b.rdy", 32'(bus.pi1_rdy_o), 32'(k % (WC + 2) == WC + 1));
        end
        bus.pi1_op_i = 2'b00;
        exp_data = ref_mem[3];
        chk("b2b.data", bus.pi1_data_o, exp_data);
        repeat (40) begin
            logic [1:0] op = 2'($urandom_range(1, 3));
            logic [29:0] a = 30'($urandom_range(0, 2 * DEPTH - 1));
            req("rand", op, a, $urandom, 4'($urandom), got);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
